// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU unit with HI/LO registers.
// One shared add/subtract datapath is stepped WIDTH times by a small FSM.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH:0]   r_upper;   // product upper half, or division remainder
    logic [WIDTH-1:0] r_lower;   // product lower half, or quotient
    logic [WIDTH-1:0] r_opb;     // multiplicand, or divisor

    logic [WIDTH:0]   w_opa;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH+1:0] w_alu;
    logic             w_borrow;

    // Divide shifts {R,Q} left before the trial subtract; multiply adds only when P[0] is set.
    always_comb begin
        w_opa    = r_is_div ? {r_upper[WIDTH-1:0], r_lower[WIDTH-1]} : r_upper;
        w_addend = (r_is_div || r_lower[0]) ? {1'b0, r_opb} : '0;
        w_alu    = r_is_div ? ({1'b0, w_opa} - {1'b0, w_addend})
                            : ({1'b0, w_opa} + {1'b0, w_addend});
        w_borrow = w_alu[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_upper  <= '0;
            r_lower  <= '0;
            r_opb    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (Signal == FN_MULTU || Signal == FN_DIVU) begin
                            r_is_div <= (Signal == FN_DIVU);
                            r_upper  <= '0;
                            r_lower  <= (Signal == FN_DIVU) ? dataA : dataB;
                            r_opb    <= (Signal == FN_DIVU) ? dataB : dataA;
                            r_cnt    <= '0;
                            busy     <= 1'b1;
                            r_state  <= S_RUN;
                        end else if (Signal == FN_MTHI) begin
                            hi <= dataA;
                        end else if (Signal == FN_MTLO) begin
                            lo <= dataA;
                        end
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        if (!w_borrow) begin
                            r_upper <= w_alu[WIDTH:0];
                            r_lower <= {r_lower[WIDTH-2:0], 1'b1};
                        end else begin
                            r_upper <= w_opa;
                            r_lower <= {r_lower[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_upper <= {1'b0, w_alu[WIDTH:1]};
                        r_lower <= {w_alu[0], r_lower[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FINISH;
                        done    <= 1'b1;
                    end
                end
                S_FINISH: begin
                    hi      <= r_upper[WIDTH-1:0];
                    lo      <= r_lower;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        if (Signal == FN_MFHI)      dataOut = hi;
        else if (Signal == FN_MFLO) dataOut = lo;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized checks of muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  Signal = 6'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo, dataOut;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue MULTU/DIVU at edge 0 and watch cycles 1..34; inj_k>0 fires a competing start.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k);
        logic [63:0] prod;
        logic [31:0] e_hi, e_lo, old_hi, old_lo;
        int busy_n, done_n, done_at;
        busy_n = 0; done_n = 0; done_at = 0;
        old_hi = m_hi; old_lo = m_lo;
        if (op == MULTU) begin
            prod = {32'd0, a} * {32'd0, b};
            e_hi = prod[63:32]; e_lo = prod[31:0];
        end else if (b == 32'd0) begin
            e_hi = a; e_lo = 32'hFFFF_FFFF;
        end else begin
            e_hi = a % b; e_lo = a / b;
        end
        @(negedge clk);
        Signal = op; dataA = a; dataB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Signal = MFHI;
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = k; end
            if (k == 5) chk("mfhi_during_busy", {32'd0, dataOut}, {32'd0, old_hi});
            if (inj_k > 0 && k == inj_k) begin
                Signal = DIVU; dataA = ~a; dataB = b + 32'd1; start = 1'b1;
            end
            if (inj_k > 0 && k == inj_k + 1) begin
                start = 1'b0; Signal = MFHI;
            end
            if (k == 33) chk("hilo_held_in_run", {hi, lo}, {old_hi, old_lo});
        end
        chk("busy_cycles", 64'(busy_n), 64'd33);
        chk("done_pulses", 64'(done_n), 64'd1);
        chk("done_cycle", 64'(done_at), 64'd33);
        chk("result_hilo", {hi, lo}, {e_hi, e_lo});
        Signal = MFLO; #1;
        chk("mflo_dataout", {32'd0, dataOut}, {32'd0, e_lo});
        m_hi = e_hi; m_lo = e_lo;
        $display("op=%b a=%h b=%h -> hi=%h lo=%h", op, a, b, hi, lo);
    endtask

    task automatic move_to(input logic [5:0] op, input logic [31:0] a);
        @(negedge clk);
        Signal = op; dataA = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == MTHI) m_hi = a; else m_lo = a;
        chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
        chk("mt_no_busy_done", {62'd0, busy, done}, 64'd0);
        $display("op=%b a=%h -> hi=%h lo=%h", op, a, hi, lo);
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {60'd0, busy, done, |hi, |lo}, 64'd0);
        Signal = MFHI; #1;
        chk("reset_dataout", {32'd0, dataOut}, 64'd0);
        reset = 1'b0;

        run_op(MULTU, 32'd7, 32'd6, 0);
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(DIVU, 32'd100, 32'd7, 0);
        run_op(DIVU, 32'h8000_0000, 32'd3, 0);
        run_op(DIVU, 32'd5, 32'd0, 0);
        move_to(MTHI, 32'hDEAD_BEEF);
        run_op(MULTU, 32'd3, 32'd3, 10);
        run_op(DIVU, 32'd1000, 32'd9, 33);

        // Reset mid-operation discards the work and clears HI/LO.
        @(negedge clk);
        Signal = MULTU; dataA = 32'd9; dataB = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("midop_reset", {62'd0, busy, done}, 64'd0);
        chk("midop_reset_hilo", {hi, lo}, 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("no_done_after_reset", 64'(done_seen), 64'd0);
        run_op(MULTU, 32'd2, 32'd3, 0);

        // start together with reset: reset wins.
        @(negedge clk);
        reset = 1'b1; Signal = MTHI; dataA = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("start_with_reset", {hi, lo}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: run_op(MULTU, ra, rb, 0);
                1: run_op(DIVU, ra, rb, 0);
                2: run_op(DIVU, ra, 32'($urandom_range(0, 15)), 0);
                3: move_to(MTHI, ra);
                default: move_to(MTLO, ra);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
